uart_tx_stage: RTL

- Serialises 8-bit result bytes from the tt_um_Nithin574 core onto a single UART line (8N1, LSB first).
- Sits directly downstream of the core: consumes its byte output through a valid/ready handshake and drives one uo_out pin.
- Lets the design be observed on the board with a plain USB-serial adapter instead of probing eight parallel pins.

---
 rtl/uart_tx_stage.sv | 127 ++++++++++++
 1 files changed

// File: rtl/uart_tx_stage.sv
// 8N1 UART transmitter fed by a valid/ready byte handshake; idle-high serial line.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frame).
module uart_tx_stage #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int DIV_W = $clog2(CLKS_PER_BIT);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             bit_end;
`ifdef UART_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    // Handshake: a byte moves on any rising edge where tx_valid and tx_ready
    // are both high; tx_valid may be held indefinitely while tx_ready is low.
    assign tx_ready   = (state_q == IDLE) & ena;
    assign busy       = (state_q != IDLE);
    assign bit_end    = (div_q == DIV_MAX);
    assign frame_done = (state_q == STOP) & bit_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        // The divider free-runs in every non-idle state and wraps at each bit boundary.
        if (state_q != IDLE) begin
            div_d = bit_end ? '0 : div_q + DIV_W'(1);
        end
        case (state_q)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    state_d = START;
                    div_d   = '0;
                    shift_d = tx_data;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^tx_data;
`endif
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        case (state_q)
            IDLE:   tx = 1'b1;
            START:  tx = 1'b0;
            DATA:   tx = shift_q[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx = par_q;
`endif
            STOP:   tx = 1'b1;
            default: tx = 1'b1;
        endcase
    end

endmodule
